mips_main_ctrl_fsm: RTL and testbench

//  Multicycle MIPS main control FSM; the producer side of the AluOp[3:0] interface consumed by ula_ctrl.

---
 rtl/mips_main_ctrl_fsm_pkg.sv | 90 +++++++++
 rtl/mips_main_ctrl_fsm_if.sv | 39 +++
 rtl/mips_main_ctrl_fsm_timer.sv | 32 +++
 rtl/mips_main_ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_mips_main_ctrl_fsm.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control: state encoding,
// opcode/func constants, AluOp codes (common with ula_ctrl) and datapath mux selects.
package mips_main_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_WB_R    = 4'd4,
        S_EXEC_I  = 4'd5,
        S_WB_I    = 4'd6,
        S_ADDR    = 4'd7,
        S_MEM_RD  = 4'd8,
        S_WB_MEM  = 4'd9,
        S_MEM_WR  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_JR      = 4'd13,
        S_ERR     = 4'd14
    } state_t;

    localparam int WAIT_MAX_DEF = 16;
    localparam int CNT_W_DEF    = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNC_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_SLTI  = 4'b0011;
    localparam logic [3:0] ALU_SLTIU = 4'b1000;
    localparam logic [3:0] ALU_ANDI  = 4'b0100;
    localparam logic [3:0] ALU_ORI   = 4'b0101;
    localparam logic [3:0] ALU_XORI  = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    function automatic logic [3:0] immAluOp(input logic [5:0] op);
        logic [3:0] code;
        code = ALU_ADD;
        case (op)
            OP_SLTI:  code = ALU_SLTI;
            OP_SLTIU: code = ALU_SLTIU;
            OP_ANDI:  code = ALU_ANDI;
            OP_ORI:   code = ALU_ORI;
            OP_XORI:  code = ALU_XORI;
            OP_LUI:   code = ALU_LUI;
            default:  code = ALU_ADD;
        endcase
        return code;
    endfunction

    function automatic logic isMemState(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_main_ctrl_fsm_if.sv
// Control/datapath bundle between the main control FSM (master) and the datapath/memory side (slave).
interface mips_main_ctrl_fsm_if;

    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;

    logic [3:0] AluOp;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       illegal;
    logic       timeout;
    logic [3:0] state_o;

    modport master (
        input  opcode, func, zero, mem_ready,
        output AluOp, AluSrcA, AluSrcB, IorD, MemRead, MemWrite, IRWrite,
               PCWrite, PCSource, RegWrite, RegDst, MemtoReg,
               illegal, timeout, state_o
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  AluOp, AluSrcA, AluSrcB, IorD, MemRead, MemWrite, IRWrite,
               PCWrite, PCSource, RegWrite, RegDst, MemtoReg,
               illegal, timeout, state_o
    );

endinterface

// File: rtl/mips_main_ctrl_fsm_timer.sv
// Memory-wait watchdog: counts cycles spent waiting for mem_ready and flags expiry
// on the last allowed cycle unless mem_ready arrives in that same cycle.
module mips_main_ctrl_fsm_timer #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inMem,
    input  logic i_memReady,
    input  logic i_stateChange,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] r_cnt;

    // Any state change restarts the count so every memory state starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_stateChange || i_memReady) begin
            r_cnt <= '0;
        end else if (i_inMem && (r_cnt != LAST_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_inMem && !i_memReady && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/mips_main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and the AluOp code consumed by ula_ctrl.
module mips_main_ctrl_fsm
    import mips_main_ctrl_fsm_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_main_ctrl_fsm_if.master   bus
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   r_timeout;
    logic   w_expire;
    logic   w_inMem;
    logic   w_stateChange;
    logic   w_decodeIllegal;

    assign w_inMem       = isMemState(r_state);
    assign w_stateChange = (w_next != r_state);

    mips_main_ctrl_fsm_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_inMem       (w_inMem),
        .i_memReady    (bus.mem_ready),
        .i_stateChange (w_stateChange),
        .o_expire      (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_decodeIllegal) begin
                r_illegal <= 1'b1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        w_decodeIllegal = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_expire) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      w_next = (bus.func == FUNC_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:  w_next = S_ADDR;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J, OP_JAL:  w_next = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: w_next = S_EXEC_I;
                    default: begin
                        w_decodeIllegal = 1'b1;
                        w_next          = S_ERR;
                    end
                endcase
            end
            S_EXEC_R: w_next = S_WB_R;
            S_WB_R:   w_next = S_FETCH;
            S_EXEC_I: w_next = S_WB_I;
            S_WB_I:   w_next = S_FETCH;
            S_ADDR:   w_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_expire) begin
                    w_next = S_ERR;
                end
            end
            S_WB_MEM: w_next = S_FETCH;
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_expire) begin
                    w_next = S_ERR;
                end
            end
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_JR:     w_next = S_FETCH;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    // Fetch commits PC and IR only in the cycle memory actually delivers the word.
    always_comb begin
        bus.AluOp    = ALU_ADD;
        bus.AluSrcA  = 1'b0;
        bus.AluSrcB  = SRCB_REGB;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSource = PCSRC_ALU;
        bus.RegWrite = 1'b0;
        bus.RegDst   = DST_RT;
        bus.MemtoReg = WB_ALUOUT;
        case (r_state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.AluSrcB = SRCB_FOUR;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.AluSrcB = SRCB_IMMSH;
            end
            S_EXEC_R: begin
                bus.AluSrcA = 1'b1;
                bus.AluOp   = ALU_RTYPE;
            end
            S_WB_R: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = DST_RD;
            end
            S_EXEC_I: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = SRCB_IMM;
                bus.AluOp   = immAluOp(bus.opcode);
            end
            S_WB_I: begin
                bus.RegWrite = 1'b1;
            end
            S_ADDR: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_WB_MEM: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = WB_MDR;
            end
            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_BRANCH: begin
                bus.AluSrcA  = 1'b1;
                bus.AluOp    = ALU_SUB;
                bus.PCSource = PCSRC_ALUOUT;
                bus.PCWrite  = ((bus.opcode == OP_BEQ) && bus.zero) ||
                               ((bus.opcode == OP_BNE) && !bus.zero);
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
                if (bus.opcode == OP_JAL) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = DST_RA;
                    bus.MemtoReg = WB_PC;
                end
            end
            S_JR: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_REGA;
            end
            default: begin
            end
        endcase
    end

    assign bus.illegal = r_illegal;
    assign bus.timeout = r_timeout;
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_mips_main_ctrl_fsm.sv
// Directed bench for mips_main_ctrl_fsm: each cycle pushes the expected state/controls
// to a scoreboard queue and pops/compares them on the falling edge.
module tb_mips_main_ctrl_fsm;
    import mips_main_ctrl_fsm_pkg::*;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [18:0] ctrl;
        logic        ill;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    exp_t sbQ[$];

    logic [18:0] obsCtrl;
    logic [18:0] wIdle, wFetchWait, wFetchGo, wDecode, wExecR, wWbR, wWbI;
    logic [18:0] wAddr, wMemRd, wWbMem, wMemWr, wJ, wJal, wJr;

    mips_main_ctrl_fsm_if bus();

    mips_main_ctrl_fsm #(.WAIT_MAX(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign obsCtrl = {bus.AluOp, bus.AluSrcA, bus.AluSrcB, bus.IorD, bus.MemRead,
                      bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.PCSource,
                      bus.RegWrite, bus.RegDst, bus.MemtoReg};

    function automatic logic [18:0] cw(input logic [3:0] aluOp, input logic srcA,
                                       input logic [1:0] srcB, input logic iord,
                                       input logic memRd, input logic memWr,
                                       input logic irW, input logic pcW,
                                       input logic [1:0] pcSrc, input logic regW,
                                       input logic [1:0] regDst, input logic [1:0] memtoReg);
        return {aluOp, srcA, srcB, iord, memRd, memWr, irW, pcW, pcSrc, regW, regDst, memtoReg};
    endfunction

    task automatic applyStimulus(input string tag, input logic r, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z, input logic rdy,
                                 input state_t st, input logic [18:0] c,
                                 input logic ill, input logic to);
        exp_t e;
        rst           = r;
        bus.opcode    = op;
        bus.func      = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        e.tag  = tag;
        e.st   = st;
        e.ctrl = c;
        e.ill  = ill;
        e.to   = to;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty got size 0 want at least 1");
            return;
        end
        e = sbQ.pop_front();
        total++;
        assert (bus.state_o === e.st) else begin
            bad++;
            $error("[TB] FAIL %s.state got %0d want %0d", e.tag, bus.state_o, e.st);
        end
        total++;
        assert (obsCtrl === e.ctrl) else begin
            bad++;
            $error("[TB] FAIL %s.ctrl got %b want %b", e.tag, obsCtrl, e.ctrl);
        end
        total++;
        assert ({bus.illegal, bus.timeout} === {e.ill, e.to}) else begin
            bad++;
            $error("[TB] FAIL %s.flags got %b want %b", e.tag,
                   {bus.illegal, bus.timeout}, {e.ill, e.to});
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy,
                        input state_t st, input logic [18:0] c,
                        input logic ill, input logic to);
        applyStimulus(tag, r, op, fn, z, rdy, st, c, ill, to);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] brOp [4];
        logic       brZ  [4];
        logic       brPc [4];

        // Field order: AluOp,SrcA,SrcB,IorD,MemRd,MemWr,IRW,PCW,PCSrc,RegW,RegDst,MemtoReg
        wIdle      = '0;
        wFetchWait = cw(4'b0000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        wFetchGo   = cw(4'b0000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
        wDecode    = cw(4'b0000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        wExecR     = cw(4'b0010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        wWbR       = cw(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00);
        wWbI       = cw(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00);
        wAddr      = cw(4'b0000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        wMemRd     = cw(4'b0000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        wWbMem     = cw(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01);
        wMemWr     = cw(4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        wJ         = cw(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00);
        wJal       = cw(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10);
        wJr        = cw(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00);

        rst           = 1'b1;
        bus.opcode    = '0;
        bus.func      = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        step("reset_idle", 1, 6'b000000, 6'b000000, 0, 1, S_IDLE, wIdle, 0, 0);
        step("idle",       0, 6'b000000, 6'b000000, 0, 1, S_IDLE, wIdle, 0, 0);

        step("add_fetch",  0, 6'b000000, 6'b100000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("add_decode", 0, 6'b000000, 6'b100000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("add_exec",   0, 6'b000000, 6'b100000, 0, 0, S_EXEC_R, wExecR,   0, 0);
        step("add_wb",     0, 6'b000000, 6'b100000, 0, 0, S_WB_R,   wWbR,     0, 0);

        step("lw_fetch",   0, 6'b100011, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("lw_decode",  0, 6'b100011, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("lw_addr",    0, 6'b100011, 6'b000000, 0, 0, S_ADDR,   wAddr,    0, 0);
        for (int i = 0; i < 3; i++)
            step("lw_memrd_wait", 0, 6'b100011, 6'b000000, 0, 0, S_MEM_RD, wMemRd, 0, 0);
        step("lw_memrd_go", 0, 6'b100011, 6'b000000, 0, 1, S_MEM_RD, wMemRd, 0, 0);
        step("lw_wbmem",    0, 6'b100011, 6'b000000, 0, 0, S_WB_MEM, wWbMem, 0, 0);

        step("sw_fetch",   0, 6'b101011, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("sw_decode",  0, 6'b101011, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("sw_addr",    0, 6'b101011, 6'b000000, 0, 0, S_ADDR,   wAddr,    0, 0);
        step("sw_memwr",   0, 6'b101011, 6'b000000, 0, 1, S_MEM_WR, wMemWr,   0, 0);

        brOp[0] = 6'b000100; brZ[0] = 1'b1; brPc[0] = 1'b1;
        brOp[1] = 6'b000100; brZ[1] = 1'b0; brPc[1] = 1'b0;
        brOp[2] = 6'b000101; brZ[2] = 1'b0; brPc[2] = 1'b1;
        brOp[3] = 6'b000101; brZ[3] = 1'b1; brPc[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("br_fetch",  0, brOp[i], 6'b000000, brZ[i], 1, S_FETCH,  wFetchGo, 0, 0);
            step("br_decode", 0, brOp[i], 6'b000000, brZ[i], 0, S_DECODE, wDecode,  0, 0);
            step("br_branch", 0, brOp[i], 6'b000000, brZ[i], 0, S_BRANCH,
                 cw(4'b0001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, brPc[i], 2'b01,
                    1'b0, 2'b00, 2'b00), 0, 0);
        end

        step("sltiu_fetch",  0, 6'b001011, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("sltiu_decode", 0, 6'b001011, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("sltiu_exec",   0, 6'b001011, 6'b000000, 0, 0, S_EXEC_I,
             cw(4'b1000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00), 0, 0);
        step("sltiu_wb",     0, 6'b001011, 6'b000000, 0, 0, S_WB_I, wWbI, 0, 0);

        step("lui_fetch",  0, 6'b001111, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("lui_decode", 0, 6'b001111, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("lui_exec",   0, 6'b001111, 6'b000000, 0, 0, S_EXEC_I,
             cw(4'b0111, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00), 0, 0);
        step("lui_wb",     0, 6'b001111, 6'b000000, 0, 0, S_WB_I, wWbI, 0, 0);

        step("jal_fetch",  0, 6'b000011, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("jal_decode", 0, 6'b000011, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("jal_jump",   0, 6'b000011, 6'b000000, 0, 0, S_JUMP,   wJal,     0, 0);

        step("jr_fetch",   0, 6'b000000, 6'b001000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("jr_decode",  0, 6'b000000, 6'b001000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("jr_jr",      0, 6'b000000, 6'b001000, 0, 0, S_JR,     wJr,      0, 0);

        // Memory answers on the last allowed waiting cycle: no timeout.
        for (int i = 0; i < 15; i++)
            step("late_fetch_wait", 0, 6'b000010, 6'b000000, 0, 0, S_FETCH, wFetchWait, 0, 0);
        step("late_fetch_go", 0, 6'b000010, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("late_decode",   0, 6'b000010, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("late_jump",     0, 6'b000010, 6'b000000, 0, 0, S_JUMP,   wJ,       0, 0);

        step("ill_fetch",  0, 6'b111111, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("ill_decode", 0, 6'b111111, 6'b000000, 0, 1, S_DECODE, wDecode,  0, 0);
        step("ill_err1",   0, 6'b111111, 6'b000000, 1, 1, S_ERR,    wIdle,    1, 0);
        step("ill_err2",   0, 6'b100011, 6'b000000, 1, 1, S_ERR,    wIdle,    1, 0);
        step("ill_rst",    1, 6'b000000, 6'b000000, 0, 1, S_ERR,    wIdle,    1, 0);
        step("ill_idle",   0, 6'b000000, 6'b000000, 0, 0, S_IDLE,   wIdle,    0, 0);

        for (int i = 0; i < 16; i++)
            step("to_fetch_wait", 0, 6'b000000, 6'b000000, 0, 0, S_FETCH, wFetchWait, 0, 0);
        step("to_err",     0, 6'b000000, 6'b000000, 0, 1, S_ERR,  wIdle, 0, 1);
        step("to_rst",     1, 6'b000000, 6'b000000, 0, 0, S_ERR,  wIdle, 0, 1);
        step("to_idle",    0, 6'b000000, 6'b000000, 0, 0, S_IDLE, wIdle, 0, 0);

        step("rsw_fetch",  0, 6'b101011, 6'b000000, 0, 1, S_FETCH,  wFetchGo, 0, 0);
        step("rsw_decode", 0, 6'b101011, 6'b000000, 0, 0, S_DECODE, wDecode,  0, 0);
        step("rsw_addr",   0, 6'b101011, 6'b000000, 0, 0, S_ADDR,   wAddr,    0, 0);
        step("rsw_memwr",  0, 6'b101011, 6'b000000, 0, 0, S_MEM_WR, wMemWr,   0, 0);
        step("rsw_rst",    1, 6'b101011, 6'b000000, 0, 0, S_MEM_WR, wMemWr,   0, 0);
        step("rsw_idle",   0, 6'b101011, 6'b000000, 0, 0, S_IDLE,   wIdle,    0, 0);
        step("rsw_fetch2", 0, 6'b101011, 6'b000000, 0, 0, S_FETCH,  wFetchWait, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
